// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states, grant encoding,
// the latched command record and the requester bit positions.
package mem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam logic [BE_W-1:0] BE_FULL = 4'hF;

    // Bit positions inside the request vector handed to the picker.
    localparam int REQ_IF  = 0;
    localparam int REQ_DM  = 1;
    localparam int REQ_DBG = 2;
    localparam int REQ_N   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2,
        GNT_DBG  = 2'd3
    } arb_gnt_t;

    // The address is not part of this record because its width is a module parameter.
    typedef struct packed {
        arb_gnt_t          owner;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } arb_cmd_t;

    function automatic logic [REQ_N-1:0] valid_onehot(input arb_gnt_t g);
        logic [REQ_N-1:0] v;
        v = '0;
        case (g)
            GNT_IF:  v[REQ_IF]  = 1'b1;
            GNT_DM:  v[REQ_DM]  = 1'b1;
            GNT_DBG: v[REQ_DBG] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority pick: DBG > DM > IF, except a starved fetch jumps ahead of DM.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic             starve,
    output arb_gnt_t         pick
);

    always_comb begin
        pick = GNT_NONE;
        if (req[REQ_DBG]) begin
            pick = GNT_DBG;
        end else if (req[REQ_IF] && starve) begin
            pick = GNT_IF;
        end else if (req[REQ_DM]) begin
            pick = GNT_DM;
        end else if (req[REQ_IF]) begin
            pick = GNT_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch, data stage and debug loader with an IDLE/ACCESS/RESP
// handshake. Define MEM_ARB_TIMEOUT_EN to build the ACCESS watchdog and sticky timeout_err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 16,
    parameter int FETCH_STARVE = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          Rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_valid,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_be,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic [31:0]   dm_rdata,
    output logic          dm_valid,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic [31:0]   dbg_rdata,
    output logic          dbg_valid,

    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_rdy,

    output logic          mem_hold,
    output logic [1:0]    gnt,
    output logic          timeout_err
);

    localparam int SW = (FETCH_STARVE < 1) ? 1 : $clog2(FETCH_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(FETCH_STARVE);

    arb_state_t       state;
    arb_cmd_t         cmd;
    arb_cmd_t         next_cmd;
    logic [AW-1:0]    cmd_addr;
    logic [AW-1:0]    next_addr;
    logic [SW-1:0]    starve_cnt;
    logic             starve;
    arb_gnt_t         pick;
    logic [REQ_N-1:0] valid_q;
    logic [31:0]      if_rdata_q;
    logic [31:0]      dm_rdata_q;
    logic [31:0]      dbg_rdata_q;
    logic             to_hit;
    logic             done;
    logic [31:0]      rdata_in;

    assign starve = (starve_cnt == STARVE_MAX);

    mem_arb_pick u_pick (
        .req    ({dbg_req, dm_req, if_req}),
        .starve (starve),
        .pick   (pick)
    );

    always_comb begin
        next_cmd       = '0;
        next_addr      = '0;
        next_cmd.owner = pick;
        case (pick)
            GNT_IF: begin
                next_cmd.we = 1'b0;
                next_cmd.be = BE_FULL;
                next_addr   = if_addr;
            end
            GNT_DM: begin
                next_cmd.we    = dm_we;
                next_cmd.be    = dm_be;
                next_cmd.wdata = dm_wdata;
                next_addr      = dm_addr;
            end
            GNT_DBG: begin
                next_cmd.we    = dbg_we;
                next_cmd.be    = BE_FULL;
                next_cmd.wdata = dbg_wdata;
                next_addr      = dbg_addr;
            end
            default: next_cmd = '0;
        endcase
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          to_err;

    // to_cnt equals the number of ACCESS cycles already spent, so the hit lands on cycle TIMEOUT.
    assign to_hit      = (state == ACCESS) && (to_cnt == TW'(TIMEOUT - 1));
    assign timeout_err = to_err;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            if (state == ACCESS && !mem_rdy && !to_hit) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                to_cnt <= '0;
            end
            if (to_hit && !mem_rdy) begin
                to_err <= 1'b1;
            end
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign done     = mem_rdy | to_hit;
    assign rdata_in = mem_rdy ? mem_rdata : 32'h0;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            cmd         <= '0;
            cmd_addr    <= '0;
            mem_req     <= 1'b0;
            valid_q     <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            valid_q <= '0;
            case (state)
                IDLE: begin
                    if (pick != GNT_NONE) begin
                        state    <= ACCESS;
                        mem_req  <= 1'b1;
                        cmd      <= next_cmd;
                        cmd_addr <= next_addr;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        valid_q <= valid_onehot(cmd.owner);
                        case (cmd.owner)
                            GNT_IF:  if_rdata_q  <= rdata_in;
                            GNT_DM:  dm_rdata_q  <= rdata_in;
                            GNT_DBG: dbg_rdata_q <= rdata_in;
                            default: ;
                        endcase
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    cmd.owner <= GNT_NONE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // A fetch that keeps losing counts up to FETCH_STARVE; any win or withdrawn request resets it.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            starve_cnt <= '0;
        end else if (!if_req) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick == GNT_IF) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    assign mem_we    = cmd.we;
    assign mem_be    = cmd.be;
    assign mem_wdata = cmd.wdata;
    assign mem_addr  = cmd_addr;
    assign gnt       = cmd.owner;

    assign if_valid  = valid_q[REQ_IF];
    assign dm_valid  = valid_q[REQ_DM];
    assign dbg_valid = valid_q[REQ_DBG];
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

    // Gated by Rst so the stall reads 0 while the block is held in reset.
    assign mem_hold = Rst & dm_req & ~((state == RESP) && (cmd.owner == GNT_DM));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, three-way contention, fetch starvation,
// stable store command, reset mid-access, and the watchdog when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    localparam int AW = 16;

    logic          clk;
    logic          Rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_valid;
    logic          dm_req;
    logic          dm_we;
    logic [3:0]    dm_be;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;
    logic          dm_valid;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic [31:0]   dbg_rdata;
    logic          dbg_valid;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_rdy;
    logic          mem_hold;
    logic [1:0]    gnt;
    logic          timeout_err;

    int checks;
    int failures;

    mem_port_arbiter #(
        .AW           (AW),
        .FETCH_STARVE (4),
        .TIMEOUT      (8)
    ) dut (
        .clk         (clk),
        .Rst         (Rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_be       (dm_be),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_valid    (dm_valid),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_rdata   (dbg_rdata),
        .dbg_valid   (dbg_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_rdy     (mem_rdy),
        .mem_hold    (mem_hold),
        .gnt         (gnt),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with the requests already driven; returns in the following IDLE cycle.
    task automatic apply_stimulus(input string tag, input logic [1:0] exp_gnt, input logic [AW-1:0] exp_addr,
                                  input logic exp_we, input logic [31:0] rdata, input bit drop);
        logic [2:0]  exp_v;
        logic [31:0] got_rd;
        exp_v = (exp_gnt == 2'd1) ? 3'b001 : (exp_gnt == 2'd2) ? 3'b010 : 3'b100;
        tick();
        check_output({tag, "_gnt"},  32'(gnt), 32'(exp_gnt));
        check_output({tag, "_req"},  32'(mem_req), 32'd1);
        check_output({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        check_output({tag, "_we"},   32'(mem_we), 32'(exp_we));
        check_output({tag, "_hold"}, 32'(mem_hold), 32'(dm_req));
        mem_rdy   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_rdy   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        check_output({tag, "_valid"}, 32'({dbg_valid, dm_valid, if_valid}), 32'(exp_v));
        got_rd = (exp_gnt == 2'd1) ? if_rdata : (exp_gnt == 2'd2) ? dm_rdata : dbg_rdata;
        check_output({tag, "_rdata"}, got_rd, rdata);
        check_output({tag, "_resp_hold"}, 32'(mem_hold), 32'(dm_req && exp_gnt != 2'd2));
        if (drop) begin
            case (exp_gnt)
                2'd1:    if_req  = 1'b0;
                2'd2:    dm_req  = 1'b0;
                default: dbg_req = 1'b0;
            endcase
        end
        tick();
        check_output({tag, "_idle_valid"}, 32'({dbg_valid, dm_valid, if_valid}), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        Rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_be     = 4'h0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;
        mem_rdata = '0;
        mem_rdy   = 1'b0;

        repeat (3) @(negedge clk);
        check_output("rst_req",   32'(mem_req), 32'd0);
        check_output("rst_gnt",   32'(gnt), 32'd0);
        check_output("rst_valid", 32'({dbg_valid, dm_valid, if_valid}), 32'd0);
        check_output("rst_hold",  32'(mem_hold), 32'd0);
        check_output("rst_ifrd",  if_rdata, 32'd0);
        check_output("rst_dmrd",  dm_rdata, 32'd0);
        check_output("rst_terr",  32'(timeout_err), 32'd0);
        Rst = 1'b1;

        // Single fetch with minimum latency.
        if_req  = 1'b1;
        if_addr = 16'h0010;
        apply_stimulus("t1if", 2'd1, 16'h0010, 1'b0, 32'h0050_0093, 1'b1);
        check_output("t1_be",     32'(mem_be), 32'hF);
        check_output("t1_gnt0",   32'(gnt), 32'd0);
        check_output("t1_ifhold", if_rdata, 32'h0050_0093);

        // mem_rdy outside ACCESS must not produce a response.
        mem_rdy = 1'b1;
        tick();
        tick();
        check_output("rdy_idle_valid", 32'({dbg_valid, dm_valid, if_valid}), 32'd0);
        check_output("rdy_idle_req",   32'(mem_req), 32'd0);
        mem_rdy = 1'b0;

        // Three simultaneous requests are served DBG, DM, IF.
        if_req   = 1'b1;  if_addr  = 16'h0050;
        dm_req   = 1'b1;  dm_addr  = 16'h0040;  dm_we = 1'b0;  dm_be = 4'hF;
        dbg_req  = 1'b1;  dbg_addr = 16'h0030;  dbg_we = 1'b0;
        #1;
        check_output("t2_hold_idle", 32'(mem_hold), 32'd1);
        apply_stimulus("t2dbg", 2'd3, 16'h0030, 1'b0, 32'h0000_D0D0, 1'b1);
        apply_stimulus("t2dm",  2'd2, 16'h0040, 1'b0, 32'h0000_D1D1, 1'b1);
        check_output("t2_hold_after", 32'(mem_hold), 32'd0);
        apply_stimulus("t2if",  2'd1, 16'h0050, 1'b0, 32'h0000_D2D2, 1'b1);

        // Fetch starvation: four DM wins, then IF, then DM again because the count cleared.
        if_req  = 1'b1;  if_addr = 16'h0088;
        dm_req  = 1'b1;  dm_addr = 16'h0044;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus($sformatf("t3dm%0d", i), 2'd2, 16'h0044, 1'b0, 32'h1000_0000 + 32'(i), 1'b0);
        end
        apply_stimulus("t3if",   2'd1, 16'h0088, 1'b0, 32'h2000_0000, 1'b0);
        apply_stimulus("t3dm_after", 2'd2, 16'h0044, 1'b0, 32'h3000_0000, 1'b1);
        if_req = 1'b0;
        tick();

        // Store whose command must stay latched while the requester changes its inputs.
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_be    = 4'b0011;
        dm_addr  = 16'h0200;
        dm_wdata = 32'hAABB_CCDD;
        tick();
        dm_we    = 1'b0;
        dm_be    = 4'hF;
        dm_addr  = 16'h0300;
        dm_wdata = 32'h0;
        for (int c = 0; c < 4; c++) begin
            check_output($sformatf("t4_c%0d_req",   c), 32'(mem_req), 32'd1);
            check_output($sformatf("t4_c%0d_we",    c), 32'(mem_we), 32'd1);
            check_output($sformatf("t4_c%0d_be",    c), 32'(mem_be), 32'h3);
            check_output($sformatf("t4_c%0d_addr",  c), 32'(mem_addr), 32'h0200);
            check_output($sformatf("t4_c%0d_wdata", c), mem_wdata, 32'hAABB_CCDD);
            if (c == 3) begin
                mem_rdy   = 1'b1;
                mem_rdata = 32'h1122_3344;
            end
            tick();
        end
        mem_rdy = 1'b0;
        check_output("t4_valid", 32'(dm_valid), 32'd1);
        check_output("t4_rdata", dm_rdata, 32'h1122_3344);
        check_output("t4_hold",  32'(mem_hold), 32'd0);
        dm_req = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: eight silent ACCESS cycles end the access with zero data.
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 16'h0080;
        tick();
        for (int c = 0; c < 8; c++) begin
            check_output($sformatf("t6_c%0d_req", c), 32'(mem_req), 32'd1);
            tick();
        end
        check_output("t6_req_drop", 32'(mem_req), 32'd0);
        check_output("t6_valid",    32'(dm_valid), 32'd1);
        check_output("t6_rdata",    dm_rdata, 32'd0);
        check_output("t6_terr",     32'(timeout_err), 32'd1);
        dm_req = 1'b0;
        tick();
        if_req  = 1'b1;
        if_addr = 16'h0090;
        apply_stimulus("t6if", 2'd1, 16'h0090, 1'b0, 32'h0000_0777, 1'b1);
        check_output("t6_terr_sticky", 32'(timeout_err), 32'd1);
`else
        check_output("t6_terr_off", 32'(timeout_err), 32'd0);
`endif

        // Reset in the middle of an access drops it immediately.
        if_req  = 1'b1;
        if_addr = 16'h0060;
        tick();
        check_output("t5_req_before", 32'(mem_req), 32'd1);
        #2;
        Rst = 1'b0;
        #1;
        check_output("t5_req",   32'(mem_req), 32'd0);
        check_output("t5_gnt",   32'(gnt), 32'd0);
        check_output("t5_addr",  32'(mem_addr), 32'd0);
        check_output("t5_ifrd",  if_rdata, 32'd0);
        check_output("t5_dmrd",  dm_rdata, 32'd0);
        check_output("t5_terr",  32'(timeout_err), 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        Rst     = 1'b1;
        if_req  = 1'b1;
        if_addr = 16'h0070;
        apply_stimulus("t5if", 2'd1, 16'h0070, 1'b0, 32'hCAFE_0001, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single instruction/data memory port between three requesters: instruction fetch (IF), the pipeline data-memory stage (DM), and the UART debug loader (DBG). It sequences each access with a req/ready handshake to memory, returns read data to the winning requester, and drives `mem_hold` so the pipeline stages, including Decode, freeze their stage registers while a data access is outstanding. It sits between the pipeline and the memory macro/UART loader on the shared bus.

## Interface
- `AW`, default 16: memory address width (byte address).
- `FETCH_STARVE`, default 4: number of consecutive lost arbitrations after which IF is promoted above DM.
- `TIMEOUT`, default 255: ACCESS-state cycle limit. Used only with `MEM_ARB_TIMEOUT_EN`.
- `clk` in 1: system clock, rising edge.
- `Rst` in 1: reset, asynchronous, active-low.
- `if_req`, `if_addr[AW-1:0]` in: fetch request. Read only.
- `if_rdata[31:0]` out, `if_valid` out 1: fetch response.
- `dm_req`, `dm_we`, `dm_be[3:0]`, `dm_addr[AW-1:0]`, `dm_wdata[31:0]` in: data request.
- `dm_rdata[31:0]` out, `dm_valid` out 1: data response.
- `dbg_req`, `dbg_we`, `dbg_addr[AW-1:0]`, `dbg_wdata[31:0]` in: debug request. Full-word writes only (be=4'hF).
- `dbg_rdata[31:0]` out, `dbg_valid` out 1: debug response.
- `mem_req`, `mem_we`, `mem_be[3:0]`, `mem_addr[AW-1:0]`, `mem_wdata[31:0]` out: memory command.
- `mem_rdata[31:0]` in, `mem_rdy` in 1: memory completion.
- `mem_hold` out 1: pipeline stall.
- `gnt[1:0]` out: current owner (0 none, 1 IF, 2 DM, 3 DBG).
- `timeout_err` out 1: sticky timeout flag.

## Operation
- FSM states:
  - IDLE: arbitrate; go to ACCESS when any request is present, else stay in IDLE.
  - ACCESS: `mem_req`=1 with the latched command. Go to RESP on `mem_rdy`=1; otherwise stay in ACCESS.
  - RESP: assert the winner's `*_valid`, then return to IDLE.
- Arbitration happens only in IDLE. Priority is DBG > DM > IF. Exception: when `starve_cnt`==`FETCH_STARVE` and `if_req`=1, IF beats DM but never beats DBG.
- `starve_cnt` (saturating):
  - Increments on each arbitration where `if_req`=1 and IF loses.
  - Clears when IF is granted or when `if_req`=0.
- On grant, the command (we, be, addr, wdata, owner) is latched. Memory outputs come from the latched copy and stay stable throughout ACCESS, even if the requester changes its inputs.
- IF accesses are forced to we=0, be=4'hF.
- `mem_rdata` is captured on the `mem_rdy` cycle into the owner's rdata register. That register holds its value until the owner's next completion.
- Requesters hold `*_req` until their `*_valid`. A request dropped before grant is simply not served.
- `mem_hold` (combinational) = `dm_req` & !(state==RESP & gnt==DM). It deasserts in the `dm_valid` cycle so the pipeline advances exactly once.
- Reset values: state IDLE; all outputs 0, including `mem_hold`, rdata registers and `timeout_err`; `starve_cnt` 0.
- Asynchronous reset mid-ACCESS drops the transaction; `mem_req` falls immediately.

## Timing
- Requests are sampled at edge 0 (IDLE). `mem_req` is high from cycle 1.
- If `mem_rdy`=1 in cycle 1+k, `*_valid` pulses for one cycle at cycle 2+k. Minimum request-to-valid latency: 2 cycles.
- RESP returns to IDLE, so back-to-back accesses cost 3 cycles minimum each.
- Simultaneous requests: one grant per IDLE cycle. Losers wait; there is no queueing beyond holding the request.
- `mem_rdy` outside ACCESS is ignored.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in ACCESS.
  - When it reaches `TIMEOUT` with no `mem_rdy`: `mem_req` drops, FSM goes to RESP, the owner's rdata is set to 32'h0, and `valid` pulses.
  - `timeout_err` sets and stays set until reset.
- Undefined: ACCESS waits indefinitely. `timeout_err` is tied 0. No counter is built.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` {IDLE, ACCESS, RESP}.
  - `arb_gnt_t` {GNT_NONE, GNT_IF, GNT_DM, GNT_DBG}.
  - Latched-command struct.
  - Width constants.
- One combinational sub-module `mem_arb_pick`: request vector + starve flag → `arb_gnt_t`. FSM, latches and counters live in the top.

## Test plan
- IF read, addr 0x0010, `mem_rdy` in first ACCESS cycle, `mem_rdata`=0x00500093 → `mem_req` in cycle 1, `if_valid` pulse in cycle 2, `if_rdata`=0x00500093, `gnt`=1 during ACCESS.
- IF+DM+DBG requests in the same cycle → grant order DBG, DM, IF. `mem_hold`=1 until the `dm_valid` cycle, 0 afterwards.
- `FETCH_STARVE`=4, `dm_req` held continuously (re-requested after each valid), `if_req`=1 → four DM grants, then the fifth grant goes to IF, then `starve_cnt` clears.
- DM store, addr 0x0200, be=4'b0011, wdata=0xAABBCCDD, `mem_rdy` after 3 wait cycles; DM inputs changed mid-ACCESS → `mem_we`=1, `mem_be`=0011, addr and data stable all 4 ACCESS cycles.
- `Rst` pulsed low mid-ACCESS → all outputs 0 without a clock edge. A new IF request after release completes normally with 2-cycle latency.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=8, `mem_rdy` held 0 → `mem_req` drops after 8 ACCESS cycles, `dm_valid` pulses with `dm_rdata`=0, and `timeout_err`=1 stays set through later accesses.
